// File: rtl/gemm_sched_pkg.sv
// Shared types, size widths and size limits for the GeMM job scheduler.
package gemm_sched_pkg;

    typedef enum logic [1:0] {SchedIdle, SchedStart, SchedRun, SchedResp} sched_state_t;
    typedef enum logic [1:0] {ErrOk = 2'd0, ErrBadSize = 2'd1, ErrTimeout = 2'd2} rsp_err_t;

    localparam int MSizeW = 6;
    localparam int KSizeW = 7;
    localparam int NSizeW = 6;

    localparam int MaxM = 32;
    localparam int MaxK = 64;
    localparam int MaxN = 32;

    // A size is usable when nonzero, tile aligned and within the datapath limit.
    function automatic logic size_ok(input logic [MSizeW-1:0] m, input logic [KSizeW-1:0] k,
                                     input logic [NSizeW-1:0] n,
                                     input int tm, input int tk, input int tn);
        return (m != '0) && (k != '0) && (n != '0) &&
               ((int'(m) % tm) == 0) && ((int'(k) % tk) == 0) && ((int'(n) % tn) == 0) &&
               (int'(m) <= MaxM) && (int'(k) <= MaxK) && (int'(n) <= MaxN);
    endfunction

endpackage

// File: rtl/gemm_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_ptr,
    output logic [NumReq-1:0] o_grant,
    output logic [IdxW-1:0]   o_idx,
    output logic              o_any
);

    always_comb begin : p_pick
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            j = int'(i_ptr) + i;
            if (j >= NumReq) j = j - NumReq;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/gemm_job_scheduler.sv
// Round-robin scheduler sharing one GeMM controller between NumReq job ports.
// Checks and latches job sizes, runs the job under an optional watchdog, returns one response.
module gemm_job_scheduler
    import gemm_sched_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int M             = 4,
    parameter int K             = 4,
    parameter int N             = 4,
    parameter int CycleWidth    = 16,
    parameter int TimeoutCycles = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_valid_i,
    output logic [NumReq-1:0]                 req_ready_o,
    input  logic [NumReq-1:0][MSizeW-1:0]     req_m_size_i,
    input  logic [NumReq-1:0][KSizeW-1:0]     req_k_size_i,
    input  logic [NumReq-1:0][NSizeW-1:0]     req_n_size_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [$clog2(NumReq)-1:0]         rsp_id_o,
    output logic [1:0]                        rsp_err_o,
    output logic [CycleWidth-1:0]             rsp_cycles_o,
    output logic                              start_o,
    output logic [MSizeW-1:0]                 m_size_o,
    output logic [KSizeW-1:0]                 k_size_o,
    output logic [NSizeW-1:0]                 n_size_o,
    input  logic                              done_i
);

    localparam int IdxW = $clog2(NumReq);
    localparam logic [CycleWidth-1:0] TmoLast = CycleWidth'(TimeoutCycles - 1);

    sched_state_t          r_state, w_state_nxt;
    logic [IdxW-1:0]       r_ptr, r_id, w_gidx, w_ptr_nxt;
    logic [NumReq-1:0]     w_grant;
    logic                  w_any, w_accept, w_size_ok, w_tmo;
    logic [MSizeW-1:0]     r_m;
    logic [KSizeW-1:0]     r_k;
    logic [NSizeW-1:0]     r_n;
    rsp_err_t              r_err;
    logic [CycleWidth-1:0] r_cnt, w_cnt_inc;

    rr_arbiter #(.NumReq(NumReq), .IdxW(IdxW)) u_arb (
        .i_req  (req_valid_i),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_idx  (w_gidx),
        .o_any  (w_any)
    );

    // Reset gates the grant so every output reads 0 while reset is held.
    assign w_accept  = (r_state == SchedIdle) && w_any && rst_ni;
    assign w_size_ok = size_ok(req_m_size_i[w_gidx], req_k_size_i[w_gidx],
                               req_n_size_i[w_gidx], M, K, N);
    assign w_tmo     = (TimeoutCycles != 0) && (r_cnt == TmoLast);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_ptr_nxt = (r_id == IdxW'(NumReq - 1)) ? '0 : r_id + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= SchedIdle;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SchedIdle:  if (w_any) w_state_nxt = w_size_ok ? SchedStart : SchedResp;
            SchedStart: w_state_nxt = SchedRun;
            SchedRun:   if (done_i || w_tmo) w_state_nxt = SchedResp;
            SchedResp:  if (rsp_ready_i) w_state_nxt = SchedIdle;
            default:    w_state_nxt = SchedIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_m   <= '0;
            r_k   <= '0;
            r_n   <= '0;
            r_err <= ErrOk;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_id  <= w_gidx;
                r_m   <= req_m_size_i[w_gidx];
                r_k   <= req_k_size_i[w_gidx];
                r_n   <= req_n_size_i[w_gidx];
                r_err <= w_size_ok ? ErrOk : ErrBadSize;
                r_cnt <= '0;
            end
            if (r_state == SchedStart) r_cnt <= '0;
            // The timeout cycle freezes the count so it reports TimeoutCycles-1.
            if (r_state == SchedRun) begin
                if (done_i) begin
                    r_err <= ErrOk;
                    r_cnt <= w_cnt_inc;
                end else if (w_tmo) begin
                    r_err <= ErrTimeout;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
            if ((r_state == SchedResp) && rsp_ready_i) r_ptr <= w_ptr_nxt;
        end
    end

    assign req_ready_o  = w_accept ? w_grant : '0;
    assign start_o      = (r_state == SchedStart);
    assign rsp_valid_o  = (r_state == SchedResp);
    assign rsp_id_o     = r_id;
    assign rsp_err_o    = r_err;
    assign rsp_cycles_o = r_cnt;
    assign m_size_o     = r_m;
    assign k_size_o     = r_k;
    assign n_size_o     = r_n;

    a_done_in_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    done_i |-> (r_state == SchedRun));

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Randomized bench for gemm_job_scheduler against a timeline-level job model.
module tb_gemm_job_scheduler;

    localparam int NR = 4;
    localparam int TO = 20;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [NR-1:0]        req_valid_i = '0;
    logic [NR-1:0]        req_ready_o;
    logic [NR-1:0][5:0]   req_m_size_i = '0;
    logic [NR-1:0][6:0]   req_k_size_i = '0;
    logic [NR-1:0][5:0]   req_n_size_i = '0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i = 1'b0;
    logic [1:0]           rsp_id_o;
    logic [1:0]           rsp_err_o;
    logic [15:0]          rsp_cycles_o;
    logic                 start_o;
    logic [5:0]           m_size_o;
    logic [6:0]           k_size_o;
    logic [5:0]           n_size_o;
    logic                 done_i = 1'b0;

    gemm_job_scheduler #(.NumReq(NR), .M(4), .K(4), .N(4), .CycleWidth(16),
                         .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_m_size_i(req_m_size_i), .req_k_size_i(req_k_size_i), .req_n_size_i(req_n_size_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_err_o(rsp_err_o), .rsp_cycles_o(rsp_cycles_o), .start_o(start_o),
        .m_size_o(m_size_o), .k_size_o(k_size_o), .n_size_o(n_size_o), .done_i(done_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    int cyc = 0, done_at = -1, start_cnt = 0, acc_cnt = 0;
    int delay_q[NR];
    bit acc_flag[NR];
    bit cont_mode = 0, drop_mode = 0, rdy_rand = 0;
    int rdy_hold = 0;
    int grant_q[$];

    // job model: one job in flight, its expected response timeline
    bit busy = 0, j_ok = 0;
    int eptr = 0, j_id, j_m, j_k, j_n, j_d, j_acc, rsp_from = -1, e_err, e_cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic bit legal(int m, int k, int n);
        return m > 0 && m % 4 == 0 && m <= 32 && k > 0 && k % 4 == 0 && k <= 64 &&
               n > 0 && n % 4 == 0 && n <= 32;
    endfunction

    always @(negedge clk_i) begin : model
        int g;
        logic [NR-1:0] er;
        bit ev;
        if (!rst_ni) begin
            busy = 0; eptr = 0; done_at = -1; rsp_from = -1;
        end else begin
            g = -1;
            if (!busy)
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (eptr + k) % NR;
                    if (g < 0 && req_valid_i[j]) g = j;
                end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(req_ready_o), 32'(er));
            if (start_o) start_cnt++;
            ev = busy && j_ok && (cyc == j_acc + 1);
            chk("start", 32'(start_o), 32'(ev));
            if (ev) begin
                chk("m_size", 32'(m_size_o), 32'(j_m));
                chk("k_size", 32'(k_size_o), 32'(j_k));
                chk("n_size", 32'(n_size_o), 32'(j_n));
                if (j_d >= 1 && j_d <= TO) begin
                    done_at = cyc + j_d; rsp_from = cyc + j_d + 1; e_err = 0; e_cyc = j_d;
                end else begin
                    done_at = -1; rsp_from = cyc + TO + 1; e_err = 2; e_cyc = TO - 1;
                end
            end
            ev = busy && rsp_from >= 0 && cyc >= rsp_from;
            chk("rsp_valid", 32'(rsp_valid_o), 32'(ev));
            if (ev) begin
                chk("rsp_id", 32'(rsp_id_o), 32'(j_id));
                chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
                chk("rsp_cycles", 32'(rsp_cycles_o), 32'(e_cyc));
                if (rsp_ready_i) begin
                    busy = 0; eptr = (j_id + 1) % NR;
                end
            end
            if (g >= 0) begin
                busy = 1; j_id = g; j_acc = cyc; j_d = delay_q[g];
                j_m = int'(req_m_size_i[g]); j_k = int'(req_k_size_i[g]); j_n = int'(req_n_size_i[g]);
                j_ok = legal(j_m, j_k, j_n);
                acc_flag[g] = 1; grant_q.push_back(g); acc_cnt++;
                if (j_ok) rsp_from = -1;
                else begin rsp_from = cyc + 1; e_err = 1; e_cyc = 0; end
            end
        end
    end

    task automatic load(input int i, input int m, input int k, input int n, input int d);
        req_m_size_i[i] = 6'(m); req_k_size_i[i] = 7'(k); req_n_size_i[i] = 6'(n);
        delay_q[i] = d; req_valid_i[i] = 1'b1;
    endtask

    task automatic load_rand(input int i, input bit only_legal);
        int m, k, n, d;
        m = (!only_legal && $urandom % 6 == 0) ? int'($urandom % 64)  : 4 * int'($urandom_range(1, 8));
        k = (!only_legal && $urandom % 6 == 0) ? int'($urandom % 128) : 4 * int'($urandom_range(1, 16));
        n = (!only_legal && $urandom % 6 == 0) ? int'($urandom % 64)  : 4 * int'($urandom_range(1, 8));
        d = (!only_legal && $urandom % 8 == 0) ? 0 : int'($urandom_range(1, TO));
        load(i, m, k, n, d);
    endtask

    task automatic step();
        @(posedge clk_i); #1;
        cyc++;
        done_i = (cyc == done_at);
        for (int i = 0; i < NR; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 0;
                if (cont_mode) load_rand(i, 1);
                else req_valid_i[i] = 1'b0;
            end else if (drop_mode && req_valid_i[i] && $urandom % 64 == 0) begin
                req_valid_i[i] = 1'b0;
            end
        end
        if (rsp_valid_o) begin
            if (rdy_hold > 0) begin rsp_ready_i = 1'b0; rdy_hold--; end
            else rsp_ready_i = rdy_rand ? 1'($urandom % 2) : 1'b1;
        end else begin
            rsp_ready_i = 1'($urandom % 2);
        end
    endtask

    task automatic wait_rsp(output int first, output int hs);
        first = -1; hs = -1;
        for (int n = 0; n < 300 && hs < 0; n++) begin
            step();
            if (rsp_valid_o && first < 0) first = cyc;
            if (rsp_valid_o && rsp_ready_i) hs = cyc;
        end
        if (hs < 0) chk("rsp_wait_expired", 0, 1);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin step(); n++; end while (!start_o && n < 100);
        if (!start_o) chk("start_wait_expired", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || req_valid_i != '0 || rsp_valid_o) && n < 3000) begin step(); n++; end
        if (n >= 3000) chk("drain_expired", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},  32'(req_ready_o), 0);
        chk({tag, "_rvalid"}, 32'(rsp_valid_o), 0);
        chk({tag, "_start"},  32'(start_o), 0);
        chk({tag, "_id"},     32'(rsp_id_o), 0);
        chk({tag, "_err"},    32'(rsp_err_o), 0);
        chk({tag, "_cycles"}, 32'(rsp_cycles_o), 0);
        chk({tag, "_sizes"},  32'({m_size_o, k_size_o, n_size_o}), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int first, hs, s0;
        int exp_ord[5];
        int tbl_m[6], tbl_k[6], tbl_n[6], tbl_e[6];
        exp_ord = '{0, 1, 2, 3, 0};
        tbl_m = '{32, 0, 36, 4, 4, 4};
        tbl_k = '{64, 4, 4, 68, 4, 4};
        tbl_n = '{32, 4, 4, 4, 2, 0};
        tbl_e = '{0, 1, 1, 1, 1, 1};
        for (int i = 0; i < NR; i++) begin delay_q[i] = 1; acc_flag[i] = 0; end

        req_valid_i = 4'b1111;
        #7;
        chk_all_zero("reset");
        req_valid_i = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // all four continuously valid: rotation from pointer 0
        cont_mode = 1; rdy_rand = 1;
        for (int i = 0; i < NR; i++) load_rand(i, 1);
        grant_q.delete();
        for (int n = 0; n < 1000 && grant_q.size() < 5; n++) step();
        cont_mode = 0;
        chk("t3_grants", 32'(grant_q.size() >= 5), 1);
        for (int i = 0; i < 5 && i < grant_q.size(); i++) chk("t3_order", 32'(grant_q[i]), 32'(exp_ord[i]));
        drain();

        // legal job, 10 cycles to done, response held off for 5 cycles
        rdy_rand = 0; rdy_hold = 5;
        s0 = start_cnt;
        load(0, 8, 16, 4, 10);
        wait_start();
        load(2, 4, 4, 4, 3);
        wait_rsp(first, hs);
        chk("t1_id", 32'(rsp_id_o), 0);
        chk("t1_err", 32'(rsp_err_o), 0);
        chk("t1_cycles", 32'(rsp_cycles_o), 10);
        chk("t5_hold", 32'(hs - first), 5);
        chk("t1_starts", 32'(start_cnt - s0), 1);
        step();
        chk("t5_next_grant", 32'(req_ready_o), 32'(4'b0100));
        wait_rsp(first, hs);
        chk("t5_job_cycles", 32'(rsp_cycles_o), 3);
        drain();

        // bad M size: immediate response, accelerator untouched
        s0 = start_cnt;
        load(1, 6, 16, 4, 5);
        wait_rsp(first, hs);
        chk("t2_id", 32'(rsp_id_o), 1);
        chk("t2_err", 32'(rsp_err_o), 1);
        chk("t2_starts", 32'(start_cnt - s0), 0);
        drain();

        for (int t = 0; t < 6; t++) begin
            load(t % NR, tbl_m[t], tbl_k[t], tbl_n[t], 2);
            wait_rsp(first, hs);
            chk("bound_err", 32'(rsp_err_o), 32'(tbl_e[t]));
            drain();
        end

        // watchdog expiry, then normal jobs; done on the timeout cycle wins
        load(2, 4, 4, 4, 0);
        wait_rsp(first, hs);
        chk("t4_err", 32'(rsp_err_o), 2);
        chk("t4_cycles", 32'(rsp_cycles_o), 19);
        load(3, 4, 4, 4, 4);
        wait_rsp(first, hs);
        chk("t4_next_err", 32'(rsp_err_o), 0);
        chk("t4_next_cycles", 32'(rsp_cycles_o), 4);
        load(0, 4, 4, 4, 20);
        wait_rsp(first, hs);
        chk("done_on_tmo_err", 32'(rsp_err_o), 0);
        chk("done_on_tmo_cycles", 32'(rsp_cycles_o), 20);
        drain();

        // random traffic
        drop_mode = 1; rdy_rand = 1;
        s0 = acc_cnt;
        for (int n = 0; n < 6000 && acc_cnt - s0 < 150; n++) begin
            step();
            if ($urandom % 3 == 0) begin
                int i;
                i = int'($urandom % NR);
                if (!req_valid_i[i] && !acc_flag[i]) load_rand(i, 0);
            end
        end
        drop_mode = 0;
        drain();

        // reset while running
        rdy_rand = 0;
        load(0, 8, 8, 8, 15);
        wait_start();
        step(); step(); step();
        load(1, 4, 4, 4, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all_zero("t6");
        req_valid_i = '0; done_i = 1'b0;
        for (int i = 0; i < NR; i++) acc_flag[i] = 0;
        step(); step();
        rst_ni = 1'b1;
        load(0, 8, 8, 8, 5);
        wait_rsp(first, hs);
        chk("t6_id", 32'(rsp_id_o), 0);
        chk("t6_err", 32'(rsp_err_o), 0);
        chk("t6_cycles", 32'(rsp_cycles_o), 5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
